// File: rtl/seq_magnitude_comparator_pkg.sv
// cmp_pkg: shared state encoding and sizing helpers for the sequential magnitude comparator.
package cmp_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: start/busy/done request bus with operands and one-hot result flags.
interface seq_magnitude_comparator_if #(parameter int WIDTH = 16);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic aeqb;
  logic agtb;
  logic altb;
  modport master (output start, signed_mode, a, b, input busy, done, aeqb, agtb, altb);
  modport slave (input start, signed_mode, a, b, output busy, done, aeqb, agtb, altb);
endinterface

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// chunk_compare: combinational CHUNK-bit unsigned comparator with MSB-priority cascaded greater term.
module chunk_compare #(parameter int CHUNK = 4) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gt
);
  always_comb begin
    logic above;
    gt = 1'b0;
    above = 1'b1;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      gt = gt | (above & a[i] & ~b[i]);
      above = above & ~(a[i] ^ b[i]);
    end
    eq = above;
  end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first multi-cycle compare, CHUNK bits per clock; CMP_EARLY_EXIT_EN stops at first unequal chunk.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  seq_magnitude_comparator_if.slave bus
);
  localparam int N = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_magnitude_comparator: WIDTH must be a positive multiple of CHUNK");
  end
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb;
  logic eq_q, gt_q, lt_q;
  logic c_eq, c_gt, decided, last, early;
  chunk_compare #(.CHUNK(CHUNK)) u_chunk (
    .a (ra[WIDTH-1 -: CHUNK]),
    .b (rb[WIDTH-1 -: CHUNK]),
    .eq(c_eq),
    .gt(c_gt)
  );
  assign decided = gt_q | lt_q;
  assign last = cnt == LAST;
`ifdef CMP_EARLY_EXIT_EN
  assign early = ~c_eq;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    nxt = state;
    if (state == IDLE && bus.start) nxt = BUSY;
    else if (state == BUSY && (last || early)) nxt = DONE;
    else if (state == DONE) nxt = IDLE;
  end
  // Operands shift left each BUSY cycle so the chunk under test is always the top one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ra <= '0;
      rb <= '0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        ra <= bus.a ^ (WIDTH'(bus.signed_mode) << (WIDTH - 1));
        rb <= bus.b ^ (WIDTH'(bus.signed_mode) << (WIDTH - 1));
        cnt <= '0;
        eq_q <= 1'b0;
        gt_q <= 1'b0;
        lt_q <= 1'b0;
      end else if (state == BUSY) begin
        ra <= ra << CHUNK;
        rb <= rb << CHUNK;
        cnt <= cnt + 1'b1;
        if (!c_eq && !decided) begin
          gt_q <= c_gt;
          lt_q <= ~c_gt;
        end
        if (last && c_eq && !decided) eq_q <= 1'b1;
      end
    end
  end
  assign bus.busy = state == BUSY;
  assign bus.done = state == DONE;
  assign bus.aeqb = eq_q;
  assign bus.agtb = gt_q;
  assign bus.altb = lt_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: directed scoreboard bench for the sequential magnitude comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;
  localparam int N = 4;
  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  seq_magnitude_comparator_if #(.WIDTH(16)) bus ();
  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic sm);
    exp_t e;
    int k;
    k = N;
    for (int i = 0; i < N; i++) begin
      if (k == N && ((ta >> (12 - 4 * i)) & 16'hF) != ((tb_ >> (12 - 4 * i)) & 16'hF)) k = i;
    end
    e.gt = sm ? ($signed(ta) > $signed(tb_)) : (ta > tb_);
    e.lt = sm ? ($signed(ta) < $signed(tb_)) : (ta < tb_);
    e.eq = ta == tb_;
`ifdef CMP_EARLY_EXIT_EN
    e.lat = (k == N) ? N : k + 1;
`else
    e.lat = N;
`endif
    return e;
  endfunction

  // Called and returns at a negedge.
  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic sm, input logic mid);
    exp_t e;
    int n;
    int nb;
    sb.push_back(model(ta, tb_, sm));
    bus.start = 1'b1;
    bus.a = ta;
    bus.b = tb_;
    bus.signed_mode = sm;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    nb = bus.busy ? 1 : 0;
    chk({tag, "_flags_clear_busy"}, {bus.aeqb, bus.agtb, bus.altb}, 0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (mid && n == 1) begin
        bus.start = 1'b1;
        bus.a = 16'hFFFF;
        bus.b = 16'h0000;
        bus.signed_mode = 1'b0;
      end else if (mid && n == 2) bus.start = 1'b0;
      if (bus.done) break;
      if (bus.busy) nb++;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_busy_cycles"}, nb, e.lat);
    chk({tag, "_aeqb"}, int'(bus.aeqb), int'(e.eq));
    chk({tag, "_agtb"}, int'(bus.agtb), int'(e.gt));
    chk({tag, "_altb"}, int'(bus.altb), int'(e.lt));
    @(negedge clk);
    chk({tag, "_done_pulse"}, {bus.done, bus.busy}, 0);
    chk({tag, "_flags_held"}, {bus.aeqb, bus.agtb, bus.altb}, {e.eq, e.gt, e.lt});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.aeqb, bus.agtb, bus.altb}, 0);
    rst = 1'b0;
    @(negedge clk);
    op("eq_u", 16'h1234, 16'h1234, 1'b0, 1'b0);
    op("gt_u_msb", 16'hA000, 16'h9FFF, 1'b0, 1'b0);
    op("lt_s", 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    op("gt_u", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op("lt_u_lsb", 16'h0005, 16'h0006, 1'b0, 1'b0);
    op("ignore_mid", 16'h0001, 16'h0002, 1'b0, 1'b1);
    op("lt_s_min", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    op("eq_s", 16'h8001, 16'h8001, 1'b1, 1'b0);
    op("gt_u_mid", 16'h12F4, 16'h1234, 1'b0, 1'b0);
    // Reset mid-BUSY with start asserted alongside it.
    bus.start = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h1235;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", {bus.busy, bus.done, bus.aeqb, bus.agtb, bus.altb}, 0);
    rst = 1'b0;
    op("after_rst", 16'h4321, 16'h4320, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, under a start/busy/done handshake. It supports unsigned and two's-complement modes, selected per operation. It produces one-hot equal/greater/less flags. It sits in the datapath wherever wide operands must be compared without a full-width single-cycle comparator.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits compared per cycle; must be ≥1. N = WIDTH/CHUNK chunks.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in BUSY.
- done  output  1  one-cycle pulse; result flags valid.
- aeqb  output  1  A == B.
- agtb  output  1  A > B.
- altb  output  1  A < B.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Reset: state IDLE, chunk counter 0, busy=0, done=0, aeqb=agtb=altb=0.
- IDLE + start=1 at edge E:
  - capture a, b and signed_mode;
  - counter := 0; clear all three flags; go BUSY.
  - In signed mode, the captured operands have their MSB inverted, so the chunk comparison remains unsigned.
- start while in BUSY or DONE is ignored; operands and mode are not re-sampled.
- BUSY, each edge, with k = counter:
  - compare chunk k of held A vs held B, where chunk 0 = bits [WIDTH-1 -: CHUNK];
  - chunk unequal: latch agtb or altb from that chunk (with CMP_EARLY_EXIT_EN, go DONE);
  - k == N-1: if no unequal chunk has been found, set aeqb; go DONE;
  - otherwise counter := k+1.
- DONE: done=1 for exactly one cycle, then IDLE.
- Flags:
  - exactly one flag is high from the DONE cycle until the next start is accepted;
  - all three are low after reset and while BUSY;
  - the first unequal chunk from the MSB alone decides gt/lt; later chunks never override it.

## Timing
- busy is registered: high in the cycles following edge E until the edge that enters DONE.
- Full-length compare:
  - DONE is entered at edge E+N; done is high in the cycle after E+N;
  - flags become valid in the same cycle as done.
- Early exit at first unequal chunk k: DONE is entered at edge E+k+1.
- The earliest next start is accepted at edge E+N+2 (full length) or E+k+3 (early exit).
- rst has priority at every edge, including mid-BUSY and in DONE: next cycle is IDLE with all outputs 0, and the operation is discarded.
- rst and start high together: rst wins; start is not accepted.

## Configuration
- CMP_EARLY_EXIT_EN
  - Defined: BUSY exits to DONE on the first unequal chunk; latency is variable, from 1 to N cycles in BUSY.
  - Undefined: BUSY always runs all N cycles; the result is latched at the first unequal chunk and held; latency is fixed at N.
  - Flag values are identical in both builds.

## Structure
- Package cmp_pkg:
  - state enum (IDLE, BUSY, DONE);
  - localparam helper for N and counter width $clog2(N) (minimum 1).
- Sub-module chunk_compare: combinational CHUNK-bit comparator with per-bit equality and cascaded MSB-priority greater term; outputs eq, gt.
- The top level holds the FSM, operand registers, counter and flag registers.

## Test plan
(WIDTH=16, CHUNK=4, N=4)
- Unsigned, a=16'h1234, b=16'h1234:
  - aeqb=1, agtb=altb=0;
  - busy for 4 cycles; done in the cycle after E+4.
- Unsigned, a=16'hA000, b=16'h9FFF:
  - agtb=1;
  - done after E+1 with CMP_EARLY_EXIT_EN, after E+4 without.
- a=16'hFFFF, b=16'h0001:
  - signed_mode=1 gives altb=1;
  - signed_mode=0 gives agtb=1.
- Unsigned, a=16'h0005, b=16'h0006:
  - altb=1;
  - done after E+4 in both builds.
- Start a=16'h0001, b=16'h0002, then pulse start with a=16'hFFFF, b=16'h0000 while busy:
  - second request ignored; result altb=1.
- Assert rst during the second BUSY cycle:
  - next cycle busy=done=0, all flags 0;
  - start on the following edge is accepted normally.
